tt_lut_engine: RTL and testbench
================================

# tt_lut_engine

Runtime-programmable truth-table evaluator. It is the parametrised successor to the fixed 4-input synthesized gate netlists: one N_IN-input Boolean function stored as a 2^N_IN-bit table. The table is reloadable through a serial config port with double buffering. The block evaluates input vectors over a valid/ready stream, and has a sweep mode that enumerates every input index so the downstream checker can compare the table against the netlist under test.

## Interface
- N_IN, 4, number of function inputs (2..8); table width TW = 2^N_IN
- TT_RESET, 16'h1AC6, active table value after reset (TW bits); bit i = output for input index i
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  eval request
- in_ready  out  1  eval request accepted when in_valid & in_ready
- in_vec  in  N_IN  input index; in_vec[0] = input _0 (LSB)
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- out_bit  out  1  table[out_idx]
- out_idx  out  N_IN  index evaluated
- out_last  out  1  final beat of a sweep
- cfg_valid  in  1  shift cfg_bit into the shadow table
- cfg_bit  in  1  serial table bit, MSB (bit TW-1) first
- cfg_commit  in  1  copy shadow to active
- cfg_err  out  1  one-cycle pulse: commit rejected
- sweep_start  in  1  start enumeration of indices 0..TW-1
- sweep_busy  out  1  high while state = SWEEP
- sweep_done  out  1  one-cycle pulse when the last sweep beat is consumed
- sweep_ones  out  N_IN+1  count of 1-bits emitted by the most recent sweep

## Operation
- Storage: active[TW], shadow[TW], cfg_cnt (saturates at TW+1).
- Config shift: on cfg_valid, shadow <= {shadow[TW-2:0], cfg_bit}, and cfg_cnt increments.
- Commit: on cfg_commit, the effective count includes a same-cycle cfg_valid bit.
  - If the count == TW, the commit is accepted: active <= shadow (including the same-cycle bit) and cfg_cnt <= 0.
  - Otherwise cfg_err pulses next cycle, active is unchanged and cfg_cnt <= 0.
- Commit during SWEEP is accepted but held pending. It is applied the cycle after the return to IDLE, so one sweep always reads one table. A second commit while one is pending overwrites the pending value.
- FSM states:
  - IDLE: evals are accepted. sweep_start moves to SWEEP with ptr <= 0 and ones <= 0.
  - SWEEP: when the output slot is free, load the slot with idx = ptr, bit = active[ptr], last = (ptr == TW-1), then ptr++. After the last beat is loaded, wait for it to be consumed, then pulse sweep_done, latch sweep_ones and return to IDLE.
- in_ready = (state == IDLE) & (!out_valid | out_ready).
- in_valid and sweep_start in the same IDLE cycle: the eval is accepted and the sweep is entered. The eval result is emitted before the sweep beats.
- sweep_start outside IDLE is ignored.
- Output slot: a single register. It holds out_bit, out_idx and out_last stable while out_valid & !out_ready (no drop, no overwrite).
- The ones counter adds out_bit on each consumed sweep beat.

## Timing
- Reset values: in_ready 0 during reset, 1 on the first cycle after. out_valid, out_bit, out_idx, out_last, cfg_err, sweep_busy, sweep_done = 0. sweep_ones = 0. active = TT_RESET, shadow = 0, cfg_cnt = 0, state IDLE, no pending commit.
- Reset mid-sweep or mid-shift aborts immediately. Any pending commit is discarded.
- Eval latency: accepted at cycle k, out_valid at k+1. Full throughput (1 per cycle) with out_ready held high.
- A commit accepted in IDLE at cycle k is used by evals accepted at k+1 onward.
- Sweep with out_ready = 1 and start at cycle k: sweep_busy from k+1, beats out_valid at k+2 .. k+1+TW, sweep_done at k+1+TW, IDLE (in_ready = 1) at k+2+TW.
- Backpressure stalls the sweep and the eval path with no lost beats.

## Test plan
- Reset then eval: with TT_RESET = 0x1AC6, stream in_vec 0..15 at 1/cycle -> out_bit sequence 0,1,1,0,0,0,1,1,0,1,0,1,1,0,0,0 with out_idx matching, latency 1.
- Sweep: sweep_start with out_ready = 1 -> 16 beats idx 0..15, out_last only on idx 15, sweep_done at k+17, sweep_ones = 7.
- Config: shift 16 bits of 0x8001 MSB first, commit -> cfg_err stays 0. Eval idx 0 -> 1, idx 15 -> 1, idx 7 -> 0. Shift 15 bits then commit -> cfg_err pulse, active unchanged.
- Backpressure: random out_ready (~50%) during a sweep and during an eval stream -> each index emitted exactly once, in order, with values stable while stalled.
- Commit during sweep: commit 0xFFFF mid-sweep -> the sweep still emits the 0x1AC6 values (sweep_ones = 7). A sweep started after the return to IDLE gives sweep_ones = 16.
- Reset mid-sweep at beat 5 -> all outputs 0 the next cycle. A new sweep starts from idx 0 with active = TT_RESET.

Source files
------------

// File: rtl/tt_lut_engine.sv
// tt_lut_engine: runtime-reloadable N_IN-input truth table (double-buffered serial config),
// 1-cycle eval over valid/ready plus index sweep; a single output slot holds its beat until out_ready.
module tt_lut_engine #(
  parameter int N_IN = 4,
  parameter logic [(1<<N_IN)-1:0] TT_RESET = 16'h1AC6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic [N_IN-1:0] out_idx,
  output logic            out_last,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  input  logic            cfg_commit,
  output logic            cfg_err,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic [N_IN:0]   sweep_ones
);

  localparam int TW = 1 << N_IN;
  localparam logic [N_IN:0] CNT_TW  = (N_IN+1)'(TW);
  localparam logic [N_IN:0] CNT_MAX = (N_IN+1)'(TW + 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SWEEP = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [N_IN:0]   ptr_q, ptr_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic [N_IN:0]   sweep_ones_q, sweep_ones_d;
  logic [TW-1:0]   active_q, active_d;
  logic [TW-1:0]   shadow_q, shadow_d;
  logic [TW-1:0]   pend_tab_q, pend_tab_d;
  logic            pend_vld_q, pend_vld_d;
  logic [N_IN:0]   cfg_cnt_q, cfg_cnt_d;
  logic            cfg_err_q, cfg_err_d;
  logic            out_valid_q, out_valid_d;
  logic            out_bit_q, out_bit_d;
  logic [N_IN-1:0] out_idx_q, out_idx_d;
  logic            out_last_q, out_last_d;
  logic            out_swp_q, out_swp_d;

  logic            slot_free, out_fire, eval_fire, last_fire, commit_ok;
  logic [TW-1:0]   shadow_nx;
  logic [N_IN:0]   cnt_nx;

  assign slot_free  = !out_valid_q || out_ready;
  assign out_fire   = out_valid_q && out_ready;
  assign in_ready   = !rst && (state_q == S_IDLE) && slot_free;
  assign eval_fire  = in_valid && in_ready;
  assign last_fire  = out_fire && out_last_q && (state_q == S_SWEEP);
  // A bit shifted in the commit cycle still counts toward the committed table.
  assign shadow_nx  = cfg_valid ? {shadow_q[TW-2:0], cfg_bit} : shadow_q;
  assign cnt_nx     = (cfg_valid && cfg_cnt_q != CNT_MAX) ? cfg_cnt_q + 1'b1 : cfg_cnt_q;
  assign commit_ok  = cnt_nx == CNT_TW;

  assign out_valid  = out_valid_q;
  assign out_bit    = out_bit_q;
  assign out_idx    = out_idx_q;
  assign out_last   = out_last_q;
  assign cfg_err    = cfg_err_q;
  assign sweep_busy = state_q == S_SWEEP;
  assign sweep_done = last_fire && !rst;
  assign sweep_ones = sweep_ones_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ones_d       = ones_q;
    sweep_ones_d = sweep_ones_q;
    active_d     = active_q;
    shadow_d     = shadow_nx;
    pend_tab_d   = pend_tab_q;
    pend_vld_d   = pend_vld_q;
    cfg_cnt_d    = cnt_nx;
    cfg_err_d    = 1'b0;
    out_valid_d  = out_valid_q;
    out_bit_d    = out_bit_q;
    out_idx_d    = out_idx_q;
    out_last_d   = out_last_q;
    out_swp_d    = out_swp_q;

    if (out_fire) out_valid_d = 1'b0;
    if (out_fire && out_swp_q) ones_d = ones_q + {{N_IN{1'b0}}, out_bit_q};

    case (state_q)
      S_IDLE: begin
        if (pend_vld_q) begin
          active_d   = pend_tab_q;
          pend_vld_d = 1'b0;
        end
        if (eval_fire) begin
          out_valid_d = 1'b1;
          out_idx_d   = in_vec;
          out_bit_d   = active_q[in_vec];
          out_last_d  = 1'b0;
          out_swp_d   = 1'b0;
        end
        if (sweep_start) begin
          state_d = S_SWEEP;
          ptr_d   = '0;
          ones_d  = '0;
        end
      end
      default: begin
        if (ptr_q != CNT_TW && slot_free) begin
          out_valid_d = 1'b1;
          out_idx_d   = ptr_q[N_IN-1:0];
          out_bit_d   = active_q[ptr_q[N_IN-1:0]];
          out_last_d  = ptr_q == CNT_TW - 1'b1;
          out_swp_d   = 1'b1;
          ptr_d       = ptr_q + 1'b1;
        end
        if (last_fire) begin
          state_d      = S_IDLE;
          sweep_ones_d = ones_q + {{N_IN{1'b0}}, out_bit_q};
        end
      end
    endcase

    // Commits landing mid-sweep are parked so a sweep never mixes two tables.
    if (cfg_commit) begin
      cfg_cnt_d = '0;
      if (!commit_ok) begin
        cfg_err_d = 1'b1;
      end else if (state_q == S_IDLE) begin
        active_d   = shadow_nx;
        pend_vld_d = 1'b0;
      end else begin
        pend_vld_d = 1'b1;
        pend_tab_d = shadow_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      ones_q       <= '0;
      sweep_ones_q <= '0;
      active_q     <= TT_RESET;
      shadow_q     <= '0;
      pend_tab_q   <= '0;
      pend_vld_q   <= 1'b0;
      cfg_cnt_q    <= '0;
      cfg_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      out_idx_q    <= '0;
      out_last_q   <= 1'b0;
      out_swp_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ones_q       <= ones_d;
      sweep_ones_q <= sweep_ones_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pend_tab_q   <= pend_tab_d;
      pend_vld_q   <= pend_vld_d;
      cfg_cnt_q    <= cfg_cnt_d;
      cfg_err_q    <= cfg_err_d;
      out_valid_q  <= out_valid_d;
      out_bit_q    <= out_bit_d;
      out_idx_q    <= out_idx_d;
      out_last_q   <= out_last_d;
      out_swp_q    <= out_swp_d;
    end
  end

endmodule

// File: tb/tb_tt_lut_engine.sv
// Bench for tt_lut_engine: directed vector tables plus randomized streams scored against a table model.
module tb_tt_lut_engine;
  localparam int TW = 16;
  localparam logic [15:0] TT_RST = 16'h1AC6;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [3:0] in_vec;
  logic       out_valid, out_ready, out_bit, out_last;
  logic [3:0] out_idx;
  logic       cfg_valid, cfg_bit, cfg_commit, cfg_err;
  logic       sweep_start, sweep_busy, sweep_done;
  logic [4:0] sweep_ones;

  tt_lut_engine #(.N_IN(4), .TT_RESET(TT_RST)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_idx(out_idx), .out_last(out_last),
    .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_commit(cfg_commit), .cfg_err(cfg_err),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .sweep_ones(sweep_ones)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] vec; logic exp_b; } vec_t;
  typedef struct { logic [3:0] idx; logic b; logic last; } beat_t;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [15:0] tab_m;
  beat_t      exp_q[$];
  bit         hold_vld = 0;
  bit         done_seen = 0;
  vec_t       tv_reset[16];
  vec_t       tv_cfg[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Start of a cycle: pulse inputs drop, caller drives fresh values.
  task automatic cyc();
    @(posedge clk);
    #1;
    in_valid = 0; cfg_valid = 0; cfg_commit = 0; sweep_start = 0;
  endtask

  task automatic smp();
    #2;
  endtask

  task automatic mon();
    if (hold_vld) chk("stall_valid", 32'(out_valid), 32'd1);
    if (out_valid) begin
      chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("beat", 32'({out_idx, out_bit, out_last}),
            32'({exp_q[0].idx, exp_q[0].b, exp_q[0].last}));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    hold_vld = out_valid && !out_ready;
    if (in_valid && in_ready) exp_q.push_back('{in_vec, tab_m[in_vec], 1'b0});
    if (sweep_done) done_seen = 1;
  endtask

  task automatic do_eval(input logic [3:0] v, input logic exp_b);
    cyc(); in_valid = 1; in_vec = v; smp();
    chk("eval_rdy", 32'(in_ready), 32'd1);
    cyc(); smp();
    chk("eval_out", 32'({out_valid, out_idx, out_bit}), 32'({1'b1, v, exp_b}));
  endtask

  task automatic shift(input logic [15:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(); cfg_valid = 1; cfg_bit = val[15-i]; smp();
    end
  endtask

  // Commit at cycle k, eval at k+1 must see the committed table when accepted.
  task automatic commit(input bit with_bit, input logic b, input bit ok,
                        input logic [3:0] v, input logic exp_b);
    cyc(); cfg_commit = 1; cfg_valid = with_bit; cfg_bit = b; smp();
    chk("cfg_err_pre", 32'(cfg_err), 32'd0);
    cyc(); in_valid = 1; in_vec = v; smp();
    chk("cfg_err", 32'(cfg_err), 32'(!ok));
    chk("commit_eval_rdy", 32'(in_ready), 32'd1);
    cyc(); smp();
    chk("cfg_err_pulse", 32'(cfg_err), 32'd0);
    chk("commit_eval", 32'({out_valid, out_idx, out_bit}), 32'({1'b1, v, exp_b}));
  endtask

  task automatic rand_evals(input int n);
    int sent = 0;
    int guard = 0;
    bit pend = 0;
    logic [3:0] v = 0;
    while ((sent < n || exp_q.size() != 0) && guard < 2000) begin
      cyc(); guard++;
      out_ready = 1'($urandom_range(0, 1));
      if (!pend && sent < n && $urandom_range(0, 3) != 0) begin
        pend = 1; v = 4'($urandom);
      end
      in_valid = pend; in_vec = v;
      smp();
      mon();
      if (in_valid && in_ready) begin pend = 0; sent++; end
    end
    chk("eval_drain", 32'(guard < 2000), 32'd1);
    out_ready = 1;
  endtask

  task automatic rand_sweep(input bit with_eval, input int commit_at,
                            input logic [15:0] new_tab, input bit rnd);
    int guard = 0;
    bit pend_c = 0;
    int exp_ones;
    done_seen = 0;
    cyc();
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    sweep_start = 1;
    if (with_eval) begin in_valid = 1; in_vec = 4'($urandom); end
    smp();
    if (with_eval) chk("eval_with_start_rdy", 32'(in_ready), 32'd1);
    mon();
    for (int i = 0; i < TW; i++) exp_q.push_back('{4'(i), tab_m[i], i == TW-1});
    while (!done_seen && guard < 300) begin
      cyc(); guard++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (guard == commit_at) begin
        cfg_valid = 1; cfg_bit = new_tab[0]; cfg_commit = 1; pend_c = 1;
      end
      smp();
      chk("sweep_busy", 32'(sweep_busy), 32'd1);
      chk("cfg_err_quiet", 32'(cfg_err), 32'd0);
      mon();
    end
    chk("sweep_done_seen", 32'(done_seen), 32'd1);
    chk("sweep_drained", 32'(exp_q.size()), 32'd0);
    exp_ones = $countones(tab_m);
    if (pend_c) tab_m = new_tab;
    cyc(); smp();
    chk("sweep_ones", 32'(sweep_ones), 32'(exp_ones));
    chk("idle_after_sweep", 32'({in_ready, sweep_busy}), 32'b10);
    out_ready = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit exp_seq[16] = '{0,1,1,0,0,0,1,1,0,1,0,1,1,0,0,0};
    int guard;
    bit found;
    for (int i = 0; i < 16; i++) tv_reset[i] = '{4'(i), exp_seq[i]};
    tv_cfg[0] = '{4'd0, 1'b1};
    tv_cfg[1] = '{4'd15, 1'b1};
    tv_cfg[2] = '{4'd7, 1'b0};
    tab_m = TT_RST;

    rst = 1; in_valid = 0; in_vec = 0; out_ready = 1;
    cfg_valid = 0; cfg_bit = 0; cfg_commit = 0; sweep_start = 0;

    // Reset state
    repeat (3) cyc();
    smp();
    chk("rdy_in_reset", 32'(in_ready), 32'd0);
    cyc(); rst = 0; smp();
    chk("rdy_after_reset", 32'(in_ready), 32'd1);
    chk("outs_after_reset",
        32'({out_valid, out_bit, out_idx, out_last, cfg_err, sweep_busy, sweep_done, sweep_ones}), 32'd0);

    // Eval stream 0..15 at full rate, latency 1
    for (int i = 0; i <= 16; i++) begin
      cyc();
      if (i < 16) begin in_valid = 1; in_vec = tv_reset[i].vec; end
      smp();
      if (i < 16) chk("ev_rdy", 32'(in_ready), 32'd1);
      if (i > 0) chk("ev_out", 32'({out_valid, out_idx, out_bit}),
                     32'({1'b1, tv_reset[i-1].vec, tv_reset[i-1].exp_b}));
    end

    // Sweep cycle timing with out_ready held high
    cyc(); sweep_start = 1; smp();
    chk("sw_start_rdy", 32'(in_ready), 32'd1);
    for (int c = 1; c <= 18; c++) begin
      cyc(); smp();
      chk("sw_busy", 32'(sweep_busy), 32'(c <= 17));
      chk("sw_valid", 32'(out_valid), 32'(c >= 2 && c <= 17));
      chk("sw_done", 32'(sweep_done), 32'(c == 17));
      chk("sw_in_ready", 32'(in_ready), 32'(c >= 18));
      if (c >= 2 && c <= 17)
        chk("sw_beat", 32'({out_idx, out_bit, out_last}),
            32'({tv_reset[c-2].vec, tv_reset[c-2].exp_b, c == 17}));
      if (c == 18) chk("sw_ones", 32'(sweep_ones), 32'd7);
    end

    // Config load 0x8001, rejected short load, then same-cycle-bit restore
    shift(16'h8001, 16);
    commit(0, 1'b0, 1, 4'd0, 1'b1);
    tab_m = 16'h8001;
    for (int i = 0; i < 3; i++) do_eval(tv_cfg[i].vec, tv_cfg[i].exp_b);
    shift(16'h1234, 15);
    commit(0, 1'b0, 0, 4'd15, 1'b1);
    do_eval(4'd1, 1'b0);
    shift(TT_RST, 15);
    commit(1, TT_RST[0], 1, 4'd6, 1'b1);
    tab_m = TT_RST;

    // Backpressure on evals and on a sweep entered together with an eval
    rand_evals(40);
    rand_sweep(1, -1, 16'h0, 1);

    // Commit mid-sweep is deferred until the sweep ends
    shift(16'hFFFF, 15);
    rand_sweep(0, 5, 16'hFFFF, 1);
    cyc(); smp();
    rand_sweep(0, -1, 16'h0, 1);

    // Reset at sweep beat 5 restores the reset table
    cyc(); sweep_start = 1; smp();
    guard = 0; found = 0;
    while (!found && guard < 40) begin
      cyc(); smp(); guard++;
      if (out_valid && out_idx == 4'd5) found = 1;
    end
    chk("reach_beat5", 32'(found), 32'd1);
    cyc(); rst = 1; smp();
    chk("rdy_in_midreset", 32'({in_ready, sweep_done}), 32'd0);
    cyc(); rst = 0; smp();
    chk("outs_after_midreset",
        32'({out_valid, out_bit, out_idx, out_last, cfg_err, sweep_busy, sweep_done, sweep_ones}), 32'd0);
    chk("rdy_after_midreset", 32'(in_ready), 32'd1);
    exp_q.delete(); hold_vld = 0; tab_m = TT_RST;
    rand_sweep(0, -1, 16'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
